squeeze_bias_relu: RTL

//  Post-accumulation stage of the fire2 squeeze layer: takes per-channel MAC accumulator results,

---
 rtl/squeeze_bias_relu.sv | 126 ++++++++++++
 1 files changed

// File: rtl/squeeze_bias_relu.sv
// squeeze_bias_relu
//   Post-accumulation stage of the fire2 squeeze layer. Each accumulator word is
//   combined with its channel's sign-magnitude bias, saturated to 16 bits and
//   optionally ReLU-clamped. The channel index comes from an internal counter.
//   The two register stages advance together under a single enable.
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   clear        synchronous flush: empties both stages, channel counter -> 0
//   bias_mem     NUM_CH x 16-bit bias table, entry i at [16*i +: 16], [15]=sign
//   acc_valid/acc_ready/acc_data   accumulator input handshake
//   out_valid/out_ready/out_data   result output handshake
//   out_ch       channel index of out_data
//   frame_done   high with the beat carrying channel NUM_CH-1
module squeeze_bias_relu #(
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned ACC_W   = 24,
    parameter bit          RELU_EN = 1'b1,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [16*NUM_CH-1:0]  bias_mem,
    input  logic                  acc_valid,
    output logic                  acc_ready,
    input  logic [ACC_W-1:0]      acc_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  frame_done
);

    localparam logic [CH_W-1:0]     LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(32767);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-32768);

    // Stage 1 registers
    logic                  r_s1_valid;
    logic [ACC_W-1:0]      r_s1_acc;
    logic [CH_W-1:0]       r_s1_ch;
    logic [15:0]           r_s1_bias;
    logic [CH_W-1:0]       r_cnt;

    // Stage 2 (output) registers
    logic                  r_out_valid;
    logic [15:0]           r_out_data;
    logic [CH_W-1:0]       r_out_ch;
    logic                  r_frame_done;

    logic                  w_en;
    logic [15:0]           w_bias_raw;
    logic [15:0]           w_bias_mag;
    logic [15:0]           w_bias_tc;
    logic signed [ACC_W:0] w_sum;
    logic [15:0]           w_sat;
    logic [15:0]           w_res;

    // Whole pipe moves when the output slot is empty or being drained
    assign w_en      = !r_out_valid || out_ready;
    assign acc_ready = w_en;

    // Sign-magnitude to two's complement; negative zero falls out as 0
    assign w_bias_raw = bias_mem[{r_cnt, 4'b0000} +: 16];
    assign w_bias_mag = {1'b0, w_bias_raw[14:0]};
    assign w_bias_tc  = w_bias_raw[15] ? (16'd0 - w_bias_mag) : w_bias_mag;

    // One extra bit so the add can never wrap before saturation
    assign w_sum = $signed({r_s1_acc[ACC_W-1], r_s1_acc})
                 + $signed({{(ACC_W - 15){r_s1_bias[15]}}, r_s1_bias});

    // Saturate to signed 16 bits, then optional ReLU
    always_comb begin
        w_sat = w_sum[15:0];
        if (w_sum > SAT_MAX) begin
            w_sat = 16'h7FFF;
        end else if (w_sum < SAT_MIN) begin
            w_sat = 16'h8000;
        end
        w_res = w_sat;
        if (RELU_EN && w_sat[15]) begin
            w_res = 16'h0000;
        end
    end

    // Pipeline registers and channel counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_acc     <= '0;
            r_s1_ch      <= '0;
            r_s1_bias    <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_frame_done <= 1'b0;
        end else if (clear) begin
            // Flush wins over any handshake; the presented input beat is dropped
            r_s1_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_cnt        <= '0;
        end else if (w_en) begin
            r_s1_valid <= acc_valid;
            if (acc_valid) begin
                r_s1_acc  <= acc_data;
                r_s1_ch   <= r_cnt;
                r_s1_bias <= w_bias_tc;
                r_cnt     <= (r_cnt == LAST_CH) ? '0 : r_cnt + CH_W'(1);
            end
            r_out_valid  <= r_s1_valid;
            r_frame_done <= r_s1_valid && (r_s1_ch == LAST_CH);
            if (r_s1_valid) begin
                r_out_data <= w_res;
                r_out_ch   <= r_s1_ch;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_ch     = r_out_ch;
    assign frame_done = r_frame_done;

endmodule
